// File: rtl/addr_sequencer.sv
// Address sweep sequencer: walks addr from a latched start to a latched finish, one step per step_en.
// Build option: define ADDR_SEQ_LOOP_EN to restart the sweep at the start bound instead of finishing.
module addr_sequencer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step_en,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_finish,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] lo_q, lo_n;
  logic [ADDR_W-1:0] hi_q, hi_n;
  logic              err_q, err_n;
  logic              done_q, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      lo_q   <= lo_n;
      hi_q   <= hi_n;
      err_q  <= err_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    err_n   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          if (addr_start <= addr_finish) begin
            lo_n    = addr_start;
            hi_n    = addr_finish;
            addr_n  = addr_start;
            state_n = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (step_en) begin
          // Increment only below the finish bound, so a finish of all-ones never wraps.
          if (addr_q < hi_q) begin
            addr_n = addr_q + 1'b1;
          end else begin
            done_n = 1'b1;
`ifdef ADDR_SEQ_LOOP_EN
            addr_n = lo_q;
`else
            state_n = DONE;
`endif
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign addr       = addr_q;
  assign addr_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = done_q;
  assign err        = err_q;

endmodule
